// File: rtl/shop_pkg.sv
// Shared definitions for the shop engine: response status codes and FSM state type.
package shop_pkg;

    // Response status encoding carried on resp_status.
    localparam logic [1:0] ST_SUCCESS        = 2'd0;
    localparam logic [1:0] ST_ERR_INVALID    = 2'd1;
    localparam logic [1:0] ST_ERR_CREDIT     = 2'd2;
    localparam logic [1:0] ST_ERR_OUT_STOCK  = 2'd3;

    // Transaction sequencing: accept in IDLE, compute discount in CALC, respond in COMMIT.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/shop_restock_timer.sv
// Free-running restock timer: pulses tick for one cycle every RESTOCK_PERIOD cycles.
module shop_restock_timer #(
    parameter int RESTOCK_PERIOD = 64
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (RESTOCK_PERIOD > 2) ? $clog2(RESTOCK_PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RESTOCK_PERIOD - 1);

    logic [CNT_W-1:0] count;

    // Count 0..RESTOCK_PERIOD-1 and wrap; the wrap cycle is the tick.
    always_ff @(posedge clk) begin
        // NOTE: registers are assigned with <= so every flop in the design samples pre-edge values.
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/shop_engine.sv
// Shop transaction engine: accepts a purchase, applies a percent discount multiplier,
// checks validity, credit and stock, then responds and updates per-item stock.
module shop_engine
    import shop_pkg::*;
#(
    parameter int N_ITEMS        = 5,
    parameter int CREDIT_W       = 10,
    parameter int STOCK_W        = 4,
    parameter int STOCK_INIT     = 5,
    parameter int STOCK_MAX      = 9,
    parameter int RESTOCK_PERIOD = 64,
    parameter int DISC_W         = 7
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           buy_valid,
    output logic                                           buy_ready,
    input  logic [((N_ITEMS > 1) ? $clog2(N_ITEMS) : 1)-1:0] action_number,
    input  logic [CREDIT_W-1:0]                            credit_in,
    input  logic [DISC_W-1:0]                              discount_mult,
    input  logic [N_ITEMS*CREDIT_W-1:0]                    prices_flat,
    output logic                                           resp_valid,
    output logic [1:0]                                     resp_status,
    output logic [CREDIT_W-1:0]                            credit_out,
    output logic [N_ITEMS-1:0]                             grant_onehot,
    output logic [N_ITEMS*STOCK_W-1:0]                     stock_flat
);

    localparam int AW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam int PW = CREDIT_W + DISC_W;
    localparam logic [STOCK_W-1:0]  STOCK_INIT_V = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0]  STOCK_MAX_V  = STOCK_W'(STOCK_MAX);
    localparam logic [CREDIT_W-1:0] CREDIT_SAT   = '1;

    state_t state;

    // Captured transaction (stable while CALC/COMMIT run, whatever the inputs do)
    logic [AW-1:0]       act_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [DISC_W-1:0]   mult_q;
    logic [CREDIT_W-1:0] price_q;
    logic [CREDIT_W-1:0] disc_q;

    logic [CREDIT_W-1:0] price_sel;
    logic [PW-1:0]       prod;
    logic [PW-1:0]       quot;
    logic [CREDIT_W-1:0] disc_c;

    logic [N_ITEMS-1:0]  item_hit;
    logic [STOCK_W-1:0]  stock_sel;
    logic [1:0]          status_c;
    logic                commit_ok;

    logic                tick;
    logic [N_ITEMS-1:0]  stock_inc;
    logic [N_ITEMS-1:0]  stock_dec;
    logic [STOCK_W-1:0]  stock [N_ITEMS];

    shop_restock_timer #(
        .RESTOCK_PERIOD(RESTOCK_PERIOD)
    ) u_restock_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign buy_ready = (state == S_IDLE);

    // Price lookup for the requested item; out-of-range actions read as zero.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        price_sel = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (action_number == AW'(i)) begin
                price_sel = prices_flat[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    // Discount = floor(price * mult / 100), saturated to the credit range.
    assign prod   = PW'(price_q) * PW'(mult_q);
    assign quot   = prod / PW'(100);
    assign disc_c = (|quot[PW-1:CREDIT_W]) ? CREDIT_SAT : quot[CREDIT_W-1:0];

    // Decode the captured action into a one-hot hit and its current stock.
    always_comb begin
        item_hit  = '0;
        stock_sel = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (act_q == AW'(i)) begin
                item_hit[i] = 1'b1;
                stock_sel   = stock[i];
            end
        end
    end

    // Status priority: invalid action, then credit, then stock.
    always_comb begin
        status_c = ST_SUCCESS;
        if (item_hit == '0) begin
            status_c = ST_ERR_INVALID;
        end else if (credit_q < disc_q) begin
            status_c = ST_ERR_CREDIT;
        end else if (stock_sel == '0) begin
            status_c = ST_ERR_OUT_STOCK;
        end
    end

    assign commit_ok = (state == S_COMMIT) && (status_c == ST_SUCCESS);

    // Transaction sequencing with registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            resp_valid   <= 1'b0;
            resp_status  <= ST_SUCCESS;
            credit_out   <= '0;
            grant_onehot <= '0;
        end else begin
            resp_valid   <= 1'b0;
            grant_onehot <= '0;
            case (state)
                S_IDLE: begin
                    if (buy_valid) begin
                        state <= S_CALC;
                    end
                end
                S_CALC: begin
                    state <= S_COMMIT;
                end
                S_COMMIT: begin
                    resp_valid  <= 1'b1;
                    resp_status <= status_c;
                    if (status_c == ST_SUCCESS) begin
                        credit_out   <= credit_q - disc_q;
                        grant_onehot <= item_hit;
                    end else begin
                        credit_out   <= credit_q;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Capture request fields on acceptance and the discount in CALC.
    always_ff @(posedge clk) begin
        // NOTE: pure datapath holding registers need no reset; they are always written before being used.
        if (state == S_IDLE && buy_valid) begin
            act_q    <= action_number;
            credit_q <= credit_in;
            mult_q   <= discount_mult;
            price_q  <= price_sel;
        end
        if (state == S_CALC) begin
            disc_q <= disc_c;
        end
    end

    // Per-item restock increment and purchase decrement requests.
    always_comb begin
        stock_inc = '0;
        stock_dec = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            stock_inc[i] = tick && (stock[i] < STOCK_MAX_V);
            stock_dec[i] = commit_ok && item_hit[i];
        end
    end

    // Stock counters: a coincident increment and decrement cancel out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ITEMS; i++) begin
            // NOTE: this register array is architectural state visible on stock_flat, so it is reset.
            if (!rst_n) begin
                stock[i] <= STOCK_INIT_V;
            end else if (stock_inc[i] && !stock_dec[i]) begin
                stock[i] <= stock[i] + STOCK_W'(1);
            end else if (stock_dec[i] && !stock_inc[i]) begin
                stock[i] <= stock[i] - STOCK_W'(1);
            end
        end
    end

    // Flatten the stock array onto the output bus.
    always_comb begin
        stock_flat = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            stock_flat[i*STOCK_W +: STOCK_W] = stock[i];
        end
    end

endmodule

// File: tb/tb_shop_engine.sv
// Self-checking bench for shop_engine: two instances (slow and fast restock) share the
// stimulus and are compared every cycle against a cycle-level behavioural model.
module tb_shop_engine;

    localparam int N    = 5;
    localparam int CW   = 10;
    localparam int SW   = 4;
    localparam int SINIT = 5;
    localparam int SMAX = 9;
    localparam int DW   = 7;
    localparam int AW   = 3;
    localparam int PER0 = 64;
    localparam int PER1 = 4;

    logic              clk;
    logic              rst_n;
    logic              buy_valid;
    logic [AW-1:0]     action_number;
    logic [CW-1:0]     credit_in;
    logic [DW-1:0]     discount_mult;
    logic [N*CW-1:0]   prices_flat;

    logic              buy_ready    [2];
    logic              resp_valid   [2];
    logic [1:0]        resp_status  [2];
    logic [CW-1:0]     credit_out   [2];
    logic [N-1:0]      grant_onehot [2];
    logic [N*SW-1:0]   stock_flat   [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int prices [N];
    int m_n;
    int m_stock [2][N];
    bit pend;
    int p_act, p_credit, p_mult, p_price, p_acc;
    bit e_rv [2];
    int e_st [2];
    int e_cr [2];
    int e_gr [2];

    shop_engine #(
        .N_ITEMS(N), .CREDIT_W(CW), .STOCK_W(SW), .STOCK_INIT(SINIT),
        .STOCK_MAX(SMAX), .RESTOCK_PERIOD(PER0), .DISC_W(DW)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .buy_valid(buy_valid), .buy_ready(buy_ready[0]),
        .action_number(action_number), .credit_in(credit_in), .discount_mult(discount_mult),
        .prices_flat(prices_flat), .resp_valid(resp_valid[0]), .resp_status(resp_status[0]),
        .credit_out(credit_out[0]), .grant_onehot(grant_onehot[0]), .stock_flat(stock_flat[0])
    );

    shop_engine #(
        .N_ITEMS(N), .CREDIT_W(CW), .STOCK_W(SW), .STOCK_INIT(SINIT),
        .STOCK_MAX(SMAX), .RESTOCK_PERIOD(PER1), .DISC_W(DW)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .buy_valid(buy_valid), .buy_ready(buy_ready[1]),
        .action_number(action_number), .credit_in(credit_in), .discount_mult(discount_mult),
        .prices_flat(prices_flat), .resp_valid(resp_valid[1]), .resp_status(resp_status[1]),
        .credit_out(credit_out[1]), .grant_onehot(grant_onehot[1]), .stock_flat(stock_flat[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int period(input int d);
        return (d == 0) ? PER0 : PER1;
    endfunction

    function automatic int get_stock(input int d, input int i);
        return int'(stock_flat[d][i*SW +: SW]);
    endfunction

    task automatic load_prices();
        for (int i = 0; i < N; i++) prices_flat[i*CW +: CW] = CW'(prices[i]);
    endtask

    // Model of one rising edge, from the rules: tick every period edges after reset,
    // response two edges after acceptance, stock judged on the value held in the commit cycle.
    task automatic model_edge();
        int disc, st, dec_item;
        bit ready_pre, tick;
        if (!rst_n) begin
            m_n  = 0;
            pend = 0;
            for (int d = 0; d < 2; d++) begin
                e_rv[d] = 0; e_st[d] = 0; e_cr[d] = 0; e_gr[d] = 0;
                for (int i = 0; i < N; i++) m_stock[d][i] = SINIT;
            end
            return;
        end
        m_n++;
        ready_pre = !pend;
        disc = p_price * p_mult / 100;
        if (disc > 1023) disc = 1023;
        for (int d = 0; d < 2; d++) begin
            e_rv[d]  = 0;
            e_gr[d]  = 0;
            dec_item = -1;
            if (pend && m_n == p_acc + 2) begin
                if (p_act >= N)                   st = 1;
                else if (p_credit < disc)         st = 2;
                else if (m_stock[d][p_act] == 0)  st = 3;
                else                              st = 0;
                e_rv[d] = 1;
                e_st[d] = st;
                e_cr[d] = (st == 0) ? p_credit - disc : p_credit;
                e_gr[d] = (st == 0) ? (1 << p_act) : 0;
                if (st == 0) dec_item = p_act;
            end
            tick = (m_n % period(d)) == 0;
            for (int i = 0; i < N; i++) begin
                if (tick && m_stock[d][i] < SMAX) m_stock[d][i]++;
                if (dec_item == i) m_stock[d][i]--;
            end
        end
        if (pend && m_n == p_acc + 2) pend = 0;
        if (ready_pre && buy_valid) begin
            pend     = 1;
            p_acc    = m_n;
            p_act    = int'(action_number);
            p_credit = int'(credit_in);
            p_mult   = int'(discount_mult);
            p_price  = (p_act < N) ? prices[p_act] : 0;
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d_ready", d), buy_ready[d], !pend);
            check($sformatf("d%0d_resp_valid", d), resp_valid[d], e_rv[d]);
            check($sformatf("d%0d_status", d), resp_status[d], e_st[d]);
            check($sformatf("d%0d_credit_out", d), credit_out[d], e_cr[d]);
            check($sformatf("d%0d_grant", d), grant_onehot[d], e_gr[d]);
            for (int i = 0; i < N; i++)
                check($sformatf("d%0d_stock%0d", d, i), get_stock(d, i), m_stock[d][i]);
        end
    endtask

    // One clock: model the rising edge, then compare on the falling edge.
    task automatic do_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        buy_valid = 1'b0;
        for (int k = 0; k < cycles; k++) do_cycle();
        rst_n = 1'b1;
    endtask

    // Issue one request from IDLE and return the slow instance's response (bounded wait).
    task automatic buy(input int act, input int credit, input int mult,
                       output int st, output int cr, output int gr);
        bit got;
        st = -1; cr = -1; gr = -1;
        action_number = AW'(act);
        credit_in     = CW'(credit);
        discount_mult = DW'(mult);
        buy_valid     = 1'b1;
        do_cycle();
        buy_valid     = 1'b0;
        credit_in     = CW'($urandom);
        discount_mult = DW'($urandom);
        action_number = AW'($urandom);
        got = 0;
        for (int k = 0; k < 4 && !got; k++) begin
            do_cycle();
            if (resp_valid[0] === 1'b1) begin
                got = 1;
                st = int'(resp_status[0]);
                cr = int'(credit_out[0]);
                gr = int'(grant_onehot[0]);
            end
        end
        if (!got) check("resp_timeout", 0, 1);
    endtask

    initial begin
        int st, cr, gr, nresp;
        int sts [6];
        rst_n = 1'b0; buy_valid = 1'b0; action_number = '0; credit_in = '0; discount_mult = '0;
        prices = '{10, 20, 200, 40, 50};
        load_prices();

        // Reset state and first request
        do_reset(3);
        check("ready_after_rst", buy_ready[0], 1);
        buy(2, 300, 50, st, cr, gr);
        check("basic_status", st, 0);
        check("basic_credit", cr, 200);
        check("basic_grant", gr, 5'b00100);
        check("basic_stock2", get_stock(0, 2), 4);

        // Invalid action
        buy(6, 123, 50, st, cr, gr);
        check("invalid_status", st, 1);
        check("invalid_credit", cr, 123);
        check("invalid_grant", gr, 0);
        check("invalid_stock2", get_stock(0, 2), 4);

        // Saturated discount
        prices[3] = 1023; load_prices();
        buy(3, 1000, 127, st, cr, gr);
        check("sat_status", st, 2);
        check("sat_credit", cr, 1000);

        // Back-to-back purchases of item 0
        do_reset(2);
        prices[0] = 1; load_prices();
        action_number = 3'd0; credit_in = 10'd500; discount_mult = 7'd100;
        buy_valid = 1'b1;
        nresp = 0;
        for (int k = 0; k < 30 && nresp < 6; k++) begin
            do_cycle();
            if (resp_valid[0] === 1'b1) begin
                sts[nresp] = int'(resp_status[0]);
                nresp++;
            end
        end
        buy_valid = 1'b0;
        check("b2b_count", nresp, 6);
        for (int k = 0; k < 5; k++) check($sformatf("b2b_success%0d", k), sts[k], 0);
        check("b2b_oos", sts[5], 3);

        // Purchase landing on a fast restock tick, then saturation
        do_reset(2);
        do_cycle();
        buy(2, 300, 50, st, cr, gr);
        check("tick_coincide_status", st, 0);
        check("tick_coincide_fast_stock2", get_stock(1, 2), 5);
        check("tick_coincide_slow_stock2", get_stock(0, 2), 4);
        for (int k = 0; k < 48; k++) do_cycle();
        for (int i = 0; i < N; i++) check($sformatf("fast_sat_stock%0d", i), get_stock(1, i), 9);

        // Reset during CALC aborts the transaction
        do_reset(2);
        buy(2, 300, 50, st, cr, gr);
        action_number = 3'd2; credit_in = 10'd300; discount_mult = 7'd50;
        buy_valid = 1'b1;
        do_cycle();
        buy_valid = 1'b0;
        rst_n = 1'b0;
        do_cycle();
        rst_n = 1'b1;
        check("abort_ready", buy_ready[0], 1);
        check("abort_stock2", get_stock(0, 2), 5);
        for (int k = 0; k < 3; k++) begin
            do_cycle();
            check("abort_no_resp", resp_valid[0], 0);
        end

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            if (k % 50 == 0) begin
                for (int i = 0; i < N; i++)
                    prices[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 150);
                load_prices();
            end
            rst_n         = ($urandom_range(0, 199) != 0);
            buy_valid     = ($urandom_range(0, 9) < 7);
            action_number = AW'($urandom_range(0, 7));
            credit_in     = CW'($urandom);
            discount_mult = DW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 100));
            do_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
